fmap_frame_packer: RTL and testbench

Upstream feeder for the max-pooling stage. Accepts a row-major pixel stream over a valid/ready handshake and assembles one H×W feature map into the flattened frame bus the pooling stage consumes. Pulses `pool_start` once the frame is complete, then holds the frame stable and stalls the stream until the pooling stage signals `done`.

---
 rtl/fmap_pkg.sv | 16 +
 rtl/pulse_rise_det.sv | 25 ++
 rtl/fmap_frame_packer.sv | 111 +++++++++++
 tb/tb_fmap_frame_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// Shared types and sizing for the feature-map frame packer.
package fmap_pkg;

    localparam int unsigned FMAP_H      = 3;
    localparam int unsigned FMAP_W      = 4;
    localparam int unsigned FRAME_ELEMS = FMAP_H * FMAP_W;
    localparam int unsigned IDX_W       = $clog2(FRAME_ELEMS);
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } fmap_state_e;

endpackage

// File: rtl/pulse_rise_det.sv
// Registers a level input and flags the cycle in which it goes from low to high.
module pulse_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d  = sig_i;
        rise_o = sig_i & ~sig_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

endmodule

// File: rtl/fmap_frame_packer.sv
// Packs a row-major pixel stream into one H x W frame and hands it to the pooling stage.
// Optional pix_last framing check is built when FMAP_PACKER_LAST_CHECK_EN is defined.
module fmap_frame_packer
    import fmap_pkg::*;
#(
    parameter int unsigned H          = FMAP_H,
    parameter int unsigned W          = FMAP_W,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [DATA_WIDTH-1:0]        pix_data,
    output logic [0:DATA_WIDTH*H*W-1]    frame_data,
    output logic                         pool_start,
    input  logic                         pool_done,
`ifdef FMAP_PACKER_LAST_CHECK_EN
    input  logic                         pix_last,
    output logic                         last_err,
`endif
    output logic [FRAME_CNT_W-1:0]       frame_cnt
);

    localparam int unsigned Elems  = H * W;
    localparam int unsigned IdxW   = (Elems > 1) ? $clog2(Elems) : 1;
    localparam int unsigned FrameW = DATA_WIDTH * Elems;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Elems - 1);

    fmap_state_e             state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [0:FrameW-1]       frame_q, frame_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic                    done_rise;
    logic                    accept;
    logic                    at_last;

    pulse_rise_det u_done_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (pool_done),
        .rise_o (done_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            idx_q       <= '0;
            frame_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL:  if (accept && at_last) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (done_rise) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // Decoded purely from state so no input reaches ready/start combinationally.
    always_comb begin
        pix_ready  = (state_q == S_FILL);
        pool_start = (state_q == S_START);
    end

    always_comb begin
        accept      = pix_valid & pix_ready;
        at_last     = (idx_q == LastIdx);
        idx_d       = idx_q;
        frame_d     = frame_q;
        frame_cnt_d = frame_cnt_q;
        if (accept) begin
            frame_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = pix_data;
            idx_d = at_last ? '0 : idx_q + 1'b1;
        end
        if (state_q == S_START) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    assign frame_data = frame_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef FMAP_PACKER_LAST_CHECK_EN
    logic last_err_q, last_err_d;

    always_comb begin
        last_err_d = last_err_q | (accept & (pix_last != at_last));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_err_q <= 1'b0;
        end else begin
            last_err_q <= last_err_d;
        end
    end

    assign last_err = last_err_q;
`endif

endmodule

// File: tb/tb_fmap_frame_packer.sv
// Directed self-checking bench for fmap_frame_packer (3x4 frame, 4-bit pixels).
module tb_fmap_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic        pix_ready;
    logic [3:0]  pix_data;
    logic [0:47] frame_data;
    logic        pool_start;
    logic        pool_done;
    logic [15:0] frame_cnt;
`ifdef FMAP_PACKER_LAST_CHECK_EN
    logic        pix_last;
    logic        last_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0]  pix [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h5, 4'h6, 4'h5,
                              4'h7, 4'h8, 4'h9, 4'h5};
    localparam logic [47:0] FRAME_A = 48'h123465657895;
    localparam logic [47:0] FRAME_B = 48'hF23465657895;

    always #5 clk = ~clk;

    fmap_frame_packer #(
        .H          (3),
        .W          (4),
        .DATA_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .frame_data (frame_data),
        .pool_start (pool_start),
        .pool_done  (pool_done),
`ifdef FMAP_PACKER_LAST_CHECK_EN
        .pix_last   (pix_last),
        .last_err   (last_err),
`endif
        .frame_cnt  (frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pool_at(input logic [0:47] f, input int r, input int c);
        logic [3:0] m;
        logic [3:0] v;
        m = 4'h0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = f[((r + dr) * 4 + (c + dc)) * 4 +: 4];
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    // Streams one full frame; element 0 is 'first', the rest come from pix[].
    task automatic feed_frame(input logic [3:0] first, input bit bubbles, input bit bad_last,
                              output int early_starts, output bit start_after_last,
                              output bit start_next, output bit err_after_11);
        early_starts = 0;
        err_after_11 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bubbles) begin
                pix_valid = 1'b0;
                step();
                if (pool_start) early_starts++;
            end
            pix_valid = 1'b1;
            pix_data  = (i == 0) ? first : pix[i];
`ifdef FMAP_PACKER_LAST_CHECK_EN
            pix_last  = (i == 11) || (bad_last && i == 10);
`endif
            step();
            if (i < 11 && pool_start) early_starts++;
`ifdef FMAP_PACKER_LAST_CHECK_EN
            if (i == 10) err_after_11 = last_err;
`endif
        end
        pix_valid = 1'b0;
`ifdef FMAP_PACKER_LAST_CHECK_EN
        pix_last  = 1'b0;
`endif
        start_after_last = pool_start;
        step();
        start_next = pool_start;
        if (bad_last) begin end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (pix_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 4'h0;
        pool_done = 1'b0;
`ifdef FMAP_PACKER_LAST_CHECK_EN
        pix_last  = 1'b0;
`endif
        step();
        step();
        checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", pix_ready); end
        checks++; if (pool_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", pool_start); end
        checks++; if (frame_data !== 48'h0) begin failures++; $display("FAIL reset_frame got=%h exp=0", frame_data); end
        checks++; if (frame_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", frame_cnt); end
`ifdef FMAP_PACKER_LAST_CHECK_EN
        checks++; if (last_err !== 1'b0) begin failures++; $display("FAIL reset_last_err got=%b exp=0", last_err); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int early;
        bit sal, sn, e11;
        logic [23:0] pooled;
        feed_frame(4'h1, 1'b0, 1'b0, early, sal, sn, e11);
        checks++; if (early !== 0) begin failures++; $display("FAIL stream_early_start got=%0d exp=0", early); end
        checks++; if (sal !== 1'b1) begin failures++; $display("FAIL stream_start_pulse got=%b exp=1", sal); end
        checks++; if (sn !== 1'b0) begin failures++; $display("FAIL stream_start_width got=%b exp=0", sn); end
        checks++; if (frame_data !== FRAME_A) begin failures++; $display("FAIL stream_frame got=%h exp=%h", frame_data, FRAME_A); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL stream_cnt got=%0d exp=1", frame_cnt); end
        checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL stream_wait_ready got=%b exp=0", pix_ready); end
        pooled = {pool_at(frame_data, 0, 0), pool_at(frame_data, 0, 1), pool_at(frame_data, 0, 2),
                  pool_at(frame_data, 1, 0), pool_at(frame_data, 1, 1), pool_at(frame_data, 1, 2)};
        checks++; if (pooled !== 24'h666899) begin failures++; $display("FAIL stream_pool got=%h exp=666899", pooled); end
`ifdef FMAP_PACKER_LAST_CHECK_EN
        checks++; if (last_err !== 1'b0) begin failures++; $display("FAIL stream_last_err got=%b exp=0", last_err); end
`endif
    endtask

    task automatic test_stall_and_done_held();
        int bad, early;
        bit ok, sal, sn, e11;
        bad = 0;
        pix_valid = 1'b1;
        pix_data  = 4'hF;
        for (int k = 0; k < 20; k++) begin
            step();
            if (pix_ready !== 1'b0 || frame_data !== FRAME_A) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); end
        pool_done = 1'b1;
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_resume ready_seen=%b exp=1", ok); end
        checks++; if (frame_data !== FRAME_A) begin failures++; $display("FAIL stall_no_write got=%h exp=%h", frame_data, FRAME_A); end
        // pool_done stays high through the whole next frame and its start pulse
        feed_frame(4'hF, 1'b0, 1'b0, early, sal, sn, e11);
        checks++; if (frame_data !== FRAME_B) begin failures++; $display("FAIL stall_frame2 got=%h exp=%h", frame_data, FRAME_B); end
        checks++; if (sal !== 1'b1 || early !== 0) begin failures++; $display("FAIL stall_start2 got=%b early=%0d exp=1 early=0", sal, early); end
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL stall_cnt2 got=%0d exp=2", frame_cnt); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (pix_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL done_held_ignored bad_cycles=%0d exp=0", bad); end
        pool_done = 1'b0;
        step();
        checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL done_fall_ready got=%b exp=0", pix_ready); end
        pool_done = 1'b1;
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL done_rerise ready_seen=%b exp=1", ok); end
        pool_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            pix_valid = 1'b1;
            pix_data  = pix[i];
            step();
        end
        pix_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", pix_ready); end
        checks++; if (pool_start !== 1'b0) begin failures++; $display("FAIL mid_reset_start got=%b exp=0", pool_start); end
        checks++; if (frame_data !== 48'h0) begin failures++; $display("FAIL mid_reset_frame got=%h exp=0", frame_data); end
        checks++; if (frame_cnt !== 16'h0) begin failures++; $display("FAIL mid_reset_cnt got=%h exp=0", frame_cnt); end
    endtask

    task automatic test_bubbles();
        int early;
        bit ok, sal, sn, e11;
        feed_frame(4'h1, 1'b1, 1'b0, early, sal, sn, e11);
        checks++; if (frame_data !== FRAME_A) begin failures++; $display("FAIL bubble_frame got=%h exp=%h", frame_data, FRAME_A); end
        checks++; if (sal !== 1'b1 || sn !== 1'b0 || early !== 0) begin failures++; $display("FAIL bubble_start got=%b%b early=%0d exp=10 early=0", sal, sn, early); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL bubble_cnt got=%0d exp=1", frame_cnt); end
        pool_done = 1'b1;
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bubble_resume ready_seen=%b exp=1", ok); end
        pool_done = 1'b0;
    endtask

`ifdef FMAP_PACKER_LAST_CHECK_EN
    task automatic test_last_check();
        int early;
        bit sal, sn, e11;
        checks++; if (last_err !== 1'b0) begin failures++; $display("FAIL last_pre got=%b exp=0", last_err); end
        feed_frame(4'h1, 1'b0, 1'b1, early, sal, sn, e11);
        checks++; if (e11 !== 1'b1) begin failures++; $display("FAIL last_err_set got=%b exp=1", e11); end
        checks++; if (sal !== 1'b1) begin failures++; $display("FAIL last_start got=%b exp=1", sal); end
        checks++; if (frame_data !== FRAME_A) begin failures++; $display("FAIL last_frame got=%h exp=%h", frame_data, FRAME_A); end
        step();
        step();
        checks++; if (last_err !== 1'b1) begin failures++; $display("FAIL last_err_sticky got=%b exp=1", last_err); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall_and_done_held();
        test_reset_mid();
        test_bubbles();
`ifdef FMAP_PACKER_LAST_CHECK_EN
        test_last_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
